// File: rtl/muldiv_issue_ctrl_if.sv
// Start/opreat_over handshake and result buses between the EX-stage
// issue controller (master) and the multiplier/divider (slave).
interface muldiv_issue_ctrl_if;
  logic        mult_start;
  logic        diver_start;
  logic        mult_sign;
  logic        div_sign;
  logic        is_busbusy;
  logic        opreat_over;
  logic [63:0] mult_result;
  logic [63:0] diver_result;

  modport master (
    output mult_start, diver_start, mult_sign, div_sign, is_busbusy,
    input  opreat_over, mult_result, diver_result
  );

  modport slave (
    input  mult_start, diver_start, mult_sign, div_sign, is_busbusy,
    output opreat_over, mult_result, diver_result
  );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// EX-stage issue controller for the multiplier/divider.
// Starts MULT/MULTU/DIV/DIVU, holds EX until the result is captured into
// HI/LO, executes MTHI/MTLO and drains ops abandoned by a flush.
//
//  state | meaning
//  IDLE  | no op in flight; may issue or execute MTHI/MTLO
//  ARM   | cycle after start; opreat_over not yet meaningful
//  WAIT  | op in flight; capture HI/LO when opreat_over rises
//  DONE  | result captured; EX released, waiting out mem_stall
//  DRAIN | flushed op still in the ALU; discard its result
module muldiv_issue_ctrl #(
  parameter bit DIV0_SKIP = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex_op_valid,
  input  logic [2:0]                 ex_op,
  input  logic [31:0]                ex_rs_data,
  input  logic [31:0]                ex_rt_data,
  input  logic                       flush,
  input  logic                       mem_stall,
  output logic                       ex_stall,
  muldiv_issue_ctrl_if.master        alu,
  output logic [31:0]                hi,
  output logic [31:0]                lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic       ex_live;
  logic       ex_is_md;
  logic       ex_is_div;
  logic       ex_div0;
  logic       go;
  logic       op_q_is_div;
  logic [2:0] sign_op;

  // Decode of the instruction currently held in EX
  always_comb begin
    ex_live     = ex_op_valid & ~flush & ~mem_stall;
    ex_is_md    = (ex_op >= OP_MULT) && (ex_op <= OP_DIVU);
    ex_is_div   = (ex_op == OP_DIV) || (ex_op == OP_DIVU);
    ex_div0     = DIV0_SKIP && ex_is_div && (ex_rt_data == 32'd0);
    go          = ex_live & ex_is_md & alu.opreat_over & ~ex_div0;
    op_q_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
    sign_op     = (state_q == S_IDLE) ? ex_op : op_q;
  end

  // Next-state, handshake outputs and HI/LO update
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    hi_d            = hi_q;
    lo_d            = lo_q;
    ex_stall        = 1'b0;
    alu.mult_start  = 1'b0;
    alu.diver_start = 1'b0;
    alu.mult_sign   = (sign_op == OP_MULT);
    alu.div_sign    = (sign_op == OP_DIV);
    alu.is_busbusy  = mem_stall;

    // The abandoned op in DRAIN never touches HI/LO, so a move need not wait for it.
    if (((state_q == S_IDLE) || (state_q == S_DRAIN)) && ex_live) begin
      if (ex_op == OP_MTHI) hi_d = ex_rs_data;
      if (ex_op == OP_MTLO) lo_d = ex_rs_data;
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          alu.mult_start  = ~ex_is_div;
          alu.diver_start = ex_is_div;
          op_d            = ex_op;
          ex_stall        = 1'b1;
          state_d         = S_ARM;
        end else if (ex_op_valid & ~flush & ex_is_md & ~ex_div0 & ~alu.opreat_over) begin
          // ALU still finishing a drained op
          ex_stall = 1'b1;
        end
      end
      S_ARM: begin
        ex_stall = 1'b1;
        state_d  = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        ex_stall = 1'b1;
        if (flush) begin
          state_d = S_DRAIN;
        end else if (alu.opreat_over) begin
          if (op_q_is_div) begin
            hi_d = alu.diver_result[63:32];
            lo_d = alu.diver_result[31:0];
          end else begin
            hi_d = alu.mult_result[63:32];
            lo_d = alu.mult_result[31:0];
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (flush || !mem_stall) state_d = S_IDLE;
      end
      S_DRAIN: begin
        ex_stall = ex_op_valid & ex_is_md;
        if (alu.opreat_over) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and architectural HI/LO registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl: directed cases followed by randomized
// instruction streams, checked against an instruction-level HI/LO model
// and a behavioural multiplier/divider responder.
module tb_muldiv_issue_ctrl;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_op_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic        flush;
  logic        mem_stall;
  logic        ex_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_issue_ctrl_if alu_if ();

  muldiv_issue_ctrl #(.DIV0_SKIP(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_op_valid (ex_op_valid),
    .ex_op       (ex_op),
    .ex_rs_data  (ex_rs_data),
    .ex_rt_data  (ex_rt_data),
    .flush       (flush),
    .mem_stall   (mem_stall),
    .ex_stall    (ex_stall),
    .alu         (alu_if),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic report();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  function automatic bit is_md(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic bit is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Arithmetic reference for the ALU: {hi,lo} of a product, {rem,quot} of a divide
  function automatic logic [63:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb, q, r;
    logic [63:0] ea, eb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      OP_MULT: begin
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return ea * eb;
      end
      OP_MULTU: begin
        ea = {32'd0, a};
        eb = {32'd0, b};
        return ea * eb;
      end
      OP_DIV: begin
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      OP_DIVU: return {a % b, a / b};
      default: return 64'd0;
    endcase
  endfunction

  // Behavioural responder: opreat_over stays high through the cycle after
  // start, then goes low for resp_lat cycles before the result appears.
  int          resp_lat = 3;
  bit          pend;
  int          cnt;
  logic [31:0] r_rs, r_rt;
  logic [2:0]  r_op;

  always @(posedge clk) begin
    if (!rst) begin
      alu_if.opreat_over  <= 1'b1;
      alu_if.mult_result  <= 64'd0;
      alu_if.diver_result <= 64'd0;
      pend <= 1'b0;
      cnt  <= 0;
    end else if (alu_if.mult_start || alu_if.diver_start) begin
      pend <= 1'b1;
      r_rs <= ex_rs_data;
      r_rt <= ex_rt_data;
      if (alu_if.mult_start) r_op <= alu_if.mult_sign ? OP_MULT : OP_MULTU;
      else                   r_op <= alu_if.div_sign ? OP_DIV : OP_DIVU;
    end else if (pend) begin
      pend <= 1'b0;
      alu_if.opreat_over <= 1'b0;
      cnt <= resp_lat - 1;
    end else if (!alu_if.opreat_over) begin
      if (cnt == 0) begin
        alu_if.opreat_over <= 1'b1;
        if (is_div(r_op)) begin
          alu_if.diver_result <= alu_model(r_op, r_rs, r_rt);
          alu_if.mult_result  <= {$urandom, $urandom};
        end else begin
          alu_if.mult_result  <= alu_model(r_op, r_rs, r_rt);
          alu_if.diver_result <= {$urandom, $urandom};
        end
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // Instruction-level architectural model and per-instruction trackers
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;
  bit started, seen_pend, captured, post_cap;
  int n_starts, stall_cnt, ms_cnt;

  // fmode: 0 none, 1 flush in first WAIT cycle, 2 flush first cycle, 3 random
  // mmode: 0 none, 1 four mem_stall cycles after capture, 2 random
  task automatic run_inst(input bit v, input logic [2:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input int fmode, input int mmode,
                          output int ncyc);
    bit done, fl, ms, stall_s, allowed, exp_start;
    logic [63:0] res;
    started = 0; seen_pend = 0; captured = 0; post_cap = 0;
    n_starts = 0; stall_cnt = 0; ms_cnt = 0;
    ex_op_valid = v; ex_op = op; ex_rs_data = rs; ex_rt_data = rt;
    done = 0;
    ncyc = 0;
    while (!done) begin
      allowed = !started || pend || !alu_if.opreat_over;
      case (fmode)
        1:       fl = started && !pend && !alu_if.opreat_over;
        2:       fl = (ncyc == 0);
        3:       fl = allowed && ($urandom_range(0, 11) == 0);
        default: fl = 1'b0;
      endcase
      case (mmode)
        1:       ms = captured && (ms_cnt < 4);
        2:       ms = ($urandom_range(0, 3) == 0);
        default: ms = 1'b0;
      endcase
      if (ms && captured) ms_cnt++;
      flush = fl;
      mem_stall = ms;

      @(negedge clk);
      if (post_cap) begin
        check("stall_after_capture", 64'(ex_stall), 64'(0));
        post_cap = 0;
      end
      if (alu_if.mult_start || alu_if.diver_start) begin
        n_starts++;
        check("start_resp_idle", 64'({alu_if.opreat_over, pend}), 64'(2'b10));
        check("start_kind", 64'({alu_if.mult_start, alu_if.diver_start}),
              64'({~is_div(op), is_div(op)}));
        started = 1;
      end
      if (started) begin
        check("mult_sign", 64'(alu_if.mult_sign), 64'(op == OP_MULT));
        check("div_sign", 64'(alu_if.div_sign), 64'(op == OP_DIV));
        if (pend) begin
          seen_pend = 1;
        end else if (seen_pend && !captured && alu_if.opreat_over && !fl) begin
          check("stall_in_capture", 64'(ex_stall), 64'(1));
          captured = 1;
          post_cap = 1;
        end
        stall_cnt += int'(ex_stall);
      end
      if (!(v && is_md(op))) check("stall_non_md", 64'(ex_stall), 64'(0));
      check("is_busbusy", 64'(alu_if.is_busbusy), 64'(ms));
      stall_s = ex_stall;

      @(posedge clk);
      #1;
      ncyc++;
      if (fl) begin
        done = 1;
        check("hi_after_kill", 64'(hi), 64'(model_hi));
        check("lo_after_kill", 64'(lo), 64'(model_lo));
      end else if (!stall_s && !ms) begin
        done = 1;
        exp_start = v && is_md(op) && !(is_div(op) && rt == 32'd0);
        check("start_count", 64'(n_starts), 64'(exp_start));
        if (exp_start) begin
          res = alu_model(op, rs, rt);
          model_hi = res[63:32];
          model_lo = res[31:0];
          check("min_stall", 64'(stall_cnt >= 3), 64'(1));
        end else if (v && op == OP_MTHI) begin
          model_hi = rs;
        end else if (v && op == OP_MTLO) begin
          model_lo = rs;
        end
        check("hi_retire", 64'(hi), 64'(model_hi));
        check("lo_retire", 64'(lo), 64'(model_lo));
      end else if (ncyc >= 300) begin
        check("inst_timeout_cycles", 64'(ncyc), 64'(0));
        report();
        $finish;
      end
    end
    flush = 1'b0;
    mem_stall = 1'b0;
    ex_op_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic [2:0]  op;
    logic [31:0] rs, rt;
    bit v;
    rst = 1'b0;
    ex_op_valid = 1'b0; ex_op = OP_NONE; ex_rs_data = 32'd0; ex_rt_data = 32'd0;
    flush = 1'b0; mem_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset clears HI/LO and outputs
    run_inst(1, OP_MTHI, 32'd5, 32'd0, 0, 0, n);
    check("t1_hi_before_reset", 64'(hi), 64'(5));
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_hi = 32'd0;
    model_lo = 32'd0;
    check("t1_hi_reset", 64'(hi), 64'(0));
    check("t1_lo_reset", 64'(lo), 64'(0));
    check("t1_stall_reset", 64'(ex_stall), 64'(0));
    check("t1_starts_reset", 64'({alu_if.mult_start, alu_if.diver_start}), 64'(0));
    check("t1_signs_reset", 64'({alu_if.mult_sign, alu_if.div_sign}), 64'(0));
    rst = 1'b1;

    // Signed multiply with a 3-cycle responder
    resp_lat = 3;
    run_inst(1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0, n);
    check("t2_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    check("t2_lo", 64'(lo), 64'(32'hFFFF_FFFA));

    // Signed divide: remainder to HI, quotient to LO
    run_inst(1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, n);
    check("t3_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    check("t3_lo", 64'(lo), 64'(32'hFFFF_FFFD));

    // Divide by zero is a one-cycle no-op
    run_inst(1, OP_DIVU, 32'd123, 32'd0, 0, 0, n);
    check("t4_cycles", 64'(n), 64'(1));
    check("t4_hi", 64'(hi), 64'(32'hFFFF_FFFF));

    // Flush during WAIT, then MULTU waits for the drain
    resp_lat = 4;
    run_inst(1, OP_MULT, 32'd7, 32'd9, 1, 0, n);
    check("t5_hi_after_flush", 64'(hi), 64'(32'hFFFF_FFFF));
    run_inst(1, OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0, n);
    check("t5_hi", 64'(hi), 64'(32'h0000_0001));
    check("t5_lo", 64'(lo), 64'(32'hFFFF_FFFE));

    // Flushed MTHI, then mem_stall held in DONE
    run_inst(1, OP_MTHI, 32'h1234, 32'd0, 2, 0, n);
    check("t6_hi_flushed_mthi", 64'(hi), 64'(32'h0000_0001));
    resp_lat = 2;
    run_inst(1, OP_MULT, 32'd100, 32'hFFFF_FFFF, 0, 1, n);
    check("t6_done_stall_cycles", 64'(ms_cnt), 64'(4));

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 9) != 0);
      op = 3'($urandom_range(0, 6));
      rs = $urandom;
      rt = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (op == OP_DIV && rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) rt = 32'd1;
      resp_lat = $urandom_range(1, 5);
      run_inst(v, op, rs, rt, 3, 2, n);
    end

    report();
    $finish;
  end

endmodule
